// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN input-side blocks: data widths, the frame
// source state encoding and the unsigned-to-INT8 pixel conversion.
package cnn_pkg;

  // Pixel and dimension widths used across the pipeline input port.
  localparam int PIX_W = 8;
  localparam int DIM_W = 8;

  // Frame source sequencing.
  //   ST_IDLE   : RAM loadable, waiting for a start
  //   ST_PRIME  : first RAM read in flight
  //   ST_STREAM : one pixel per unstalled cycle, next address prefetched
  //   ST_GAP    : idle cycles between rows
  //   ST_FINISH : one-cycle done pulse
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_STREAM = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Unsigned 0..255 to signed INT8 (value - 128): flipping the MSB is the
  // same as subtracting 128 in two's complement.
  function automatic logic signed [PIX_W-1:0] u8_to_int8(input logic [PIX_W-1:0] d);
    return {~d[PIX_W-1], d[PIX_W-2:0]};
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Frame buffer: one write port and one read port on a single clock, with a
// registered read that holds its last value when no read is issued.
module frame_ram #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Host load port; the caller decides when writes are allowed.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Synchronous read with hold, so a stalled stream keeps its pixel.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pixel_stream_source.sv
// Host-loadable frame source for the CNN input port. An image of unsigned
// bytes is loaded into local RAM while idle, then streamed row-major as
// signed INT8 on a valid/pixel interface with optional inter-row gaps and
// a consumer stall that freezes the stream without losing pixels.
module pixel_stream_source
  import cnn_pkg::*;
#(
  parameter int MAX_DIM = 64,
  parameter int ADDR_W  = 12,
  parameter int ROW_GAP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [PIX_W-1:0]        wr_data,
  input  logic [DIM_W-1:0]        img_width,
  input  logic [DIM_W-1:0]        img_height,
  input  logic                    start,
  input  logic                    stall,
  output logic                    valid_in,
  output logic signed [PIX_W-1:0] pixel_in,
  output logic [DIM_W-1:0]        row_idx,
  output logic [DIM_W-1:0]        col_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;
  // Gap counter only needs to reach ROW_GAP-1; keep at least one bit so the
  // gapless build still elaborates cleanly.
  localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  w_q, w_d;
  logic [DIM_W-1:0]  h_q, h_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              cfg_err_q, cfg_err_d;

  logic              ram_we;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;

  logic              dims_bad;
  logic              last_col;
  logic              last_row;
  logic              gap_last;

  // The RAM is only loadable while no frame is in flight.
  assign ram_we = wr_en && (state_q == ST_IDLE);

  frame_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(PIX_W)
  ) u_frame_ram (
    .clk      (clk),
    .wr_en_i  (ram_we),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  assign dims_bad = (img_width == '0) || (img_height == '0) ||
                    (int'(img_width) > MAX_DIM) || (int'(img_height) > MAX_DIM);

  // row_q/col_q always describe the pixel currently sitting in rd_data.
  assign last_col = (col_q == w_q - DIM_W'(1));
  assign last_row = (row_q == h_q - DIM_W'(1));
  assign gap_last = (int'(gap_q) >= ROW_GAP - 1);

  // State and datapath registers; async reset puts every output at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      gap_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      row_q     <= row_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      gap_q     <= gap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state logic, counters and RAM read control.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    gap_d     = gap_q;
    cfg_err_d = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dims_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            // Dimensions are frozen here; later changes are ignored.
            w_d     = img_width;
            h_d     = img_height;
            row_d   = '0;
            col_d   = '0;
            addr_d  = '0;
            state_d = ST_PRIME;
          end
        end
      end

      ST_PRIME: begin
        // Fetch pixel 0 so it is waiting in rd_data on the first STREAM cycle.
        rd_en   = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_STREAM;
      end

      ST_STREAM: begin
        // A stalled cycle changes nothing: counters, address and rd_data hold.
        if (!stall) begin
          if (last_col && last_row) begin
            state_d = ST_FINISH;
          end else begin
            // Prefetch the next pixel; the address is a plain linear count.
            rd_en  = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            if (last_col) begin
              col_d = '0;
              row_d = row_q + DIM_W'(1);
              if (ROW_GAP > 0) begin
                gap_d   = '0;
                state_d = ST_GAP;
              end
            end else begin
              col_d = col_q + DIM_W'(1);
            end
          end
        end
      end

      ST_GAP: begin
        // Only unstalled cycles count toward the gap, so a stall stretches it.
        if (!stall) begin
          if (gap_last) begin
            state_d = ST_STREAM;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      ST_FINISH: begin
        // start is deliberately not looked at here; the next IDLE cycle can
        // accept it, which gives back-to-back frames.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The registered candidate is gated by stall in the same cycle.
  assign valid_in = (state_q == ST_STREAM) && !stall;
  assign pixel_in = valid_in ? u8_to_int8(rd_data) : '0;
  assign row_idx  = row_q;
  assign col_idx  = col_q;
  assign busy     = (state_q == ST_PRIME) || (state_q == ST_STREAM) || (state_q == ST_GAP);
  assign done     = (state_q == ST_FINISH);
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: a gapless and a ROW_GAP=2 instance share the
// same stimulus; a pixel-index model per instance predicts every cycle.
module tb_pixel_stream_source;

  localparam int MAX_DIM = 64;
  localparam int ADDR_W  = 12;
  localparam int NPIX    = MAX_DIM * MAX_DIM;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic [7:0]        img_width = '0;
  logic [7:0]        img_height = '0;
  logic              start = 1'b0;
  logic              stall = 1'b0;

  logic [1:0]        valid_w, busy_w, done_w, err_w;
  logic signed [7:0] pix_w [2];
  logic [7:0]        row_w [2];
  logic [7:0]        col_w [2];

  always #5 clk = ~clk;

  pixel_stream_source #(.MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W), .ROW_GAP(0)) dut_gap0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .img_width(img_width), .img_height(img_height), .start(start), .stall(stall),
    .valid_in(valid_w[0]), .pixel_in(pix_w[0]), .row_idx(row_w[0]), .col_idx(col_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .cfg_err(err_w[0])
  );

  pixel_stream_source #(.MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W), .ROW_GAP(2)) dut_gap2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .img_width(img_width), .img_height(img_height), .start(start), .stall(stall),
    .valid_in(valid_w[1]), .pixel_in(pix_w[1]), .row_idx(row_w[1]), .col_idx(col_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .cfg_err(err_w[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input integer got, input integer exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame described by pixel index k, plain arithmetic for row/col.
  int gap_cfg [2] = '{0, 2};
  int m_act   [2] = '{0, 0};   // frame in progress (busy)
  int m_prime [2] = '{0, 0};   // first read in flight
  int m_fin   [2] = '{0, 0};   // done cycle
  int m_err   [2] = '{0, 0};   // cfg_err cycle
  int m_k     [2] = '{0, 0};   // pixels delivered so far
  int m_wait  [2] = '{0, 0};   // unstalled idle cycles owed before next pixel
  int m_w     [2] = '{0, 0};
  int m_h     [2] = '{0, 0};
  int m_vcnt  [2] = '{0, 0};   // valids actually seen from the DUT
  int m_mem   [2][NPIX];

  // Model advance on each active edge, using the inputs the DUT saw.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 0; m_prime[i] = 0; m_fin[i] = 0; m_err[i] = 0;
      end else begin
        m_err[i] = 0;
        if (m_fin[i] != 0) begin
          m_fin[i] = 0;
        end else if (m_act[i] != 0) begin
          if (m_prime[i] != 0) begin
            m_prime[i] = 0;
          end else if (m_wait[i] > 0) begin
            if (!stall) m_wait[i]--;
          end else if (!stall) begin
            m_k[i]++;
            if (m_k[i] == m_w[i] * m_h[i]) begin
              m_act[i] = 0;
              m_fin[i] = 1;
            end else if (m_k[i] % m_w[i] == 0) begin
              m_wait[i] = gap_cfg[i];
            end
          end
        end else begin
          if (wr_en) m_mem[i][wr_addr] = int'(wr_data);
          if (start) begin
            if (img_width == 0 || img_height == 0 || img_width > MAX_DIM || img_height > MAX_DIM) begin
              m_err[i] = 1;
              $display("gap%0d start rejected w=%0d h=%0d", gap_cfg[i], img_width, img_height);
            end else begin
              m_act[i] = 1; m_prime[i] = 1; m_k[i] = 0; m_wait[i] = 0;
              m_w[i] = int'(img_width); m_h[i] = int'(img_height); m_vcnt[i] = 0;
              $display("gap%0d frame start w=%0d h=%0d", gap_cfg[i], m_w[i], m_h[i]);
            end
          end
        end
      end
    end
  end

  // Compare every output of both instances on the falling edge.
  always @(negedge clk) begin
    int exp_v;
    string p;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "gap0" : "gap2";
      if (rst) begin
        m_act[i] = 0; m_prime[i] = 0; m_fin[i] = 0; m_err[i] = 0;
        check({p, "_rst_valid"}, valid_w[i], 0);
        check({p, "_rst_busy"}, busy_w[i], 0);
        check({p, "_rst_done"}, done_w[i], 0);
        check({p, "_rst_cfg_err"}, err_w[i], 0);
        check({p, "_rst_pixel"}, pix_w[i], 0);
        check({p, "_rst_row"}, row_w[i], 0);
        check({p, "_rst_col"}, col_w[i], 0);
      end else begin
        exp_v = (m_act[i] != 0 && m_prime[i] == 0 && m_wait[i] == 0 && !stall) ? 1 : 0;
        check({p, "_valid"}, valid_w[i], exp_v);
        check({p, "_busy"}, busy_w[i], m_act[i]);
        check({p, "_done"}, done_w[i], m_fin[i]);
        check({p, "_cfg_err"}, err_w[i], m_err[i]);
        if (exp_v != 0 && valid_w[i] === 1'b1) begin
          check({p, "_pixel"}, pix_w[i], m_mem[i][m_k[i]] - 128);
          check({p, "_row"}, row_w[i], m_k[i] / m_w[i]);
          check({p, "_col"}, col_w[i], m_k[i] % m_w[i]);
        end
        if (valid_w[i] === 1'b1) m_vcnt[i]++;
        if (m_fin[i] != 0) begin
          check({p, "_frame_valids"}, m_vcnt[i], m_w[i] * m_h[i]);
          $display("gap%0d frame done valids=%0d", gap_cfg[i], m_vcnt[i]);
        end
      end
    end
  end

  function automatic bit both_idle();
    return m_act[0] == 0 && m_fin[0] == 0 && m_act[1] == 0 && m_fin[1] == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ramp, 1: random, 2: conversion corner values
  task automatic load(input int w, input int h, input int mode);
    int v;
    for (int k = 0; k < w * h; k++) begin
      case (mode)
        0:       v = k % 256;
        1:       v = int'($urandom_range(0, 255));
        default: v = (k % 4 == 0) ? 0 : (k % 4 == 1) ? 128 : (k % 4 == 2) ? 255 : 127;
      endcase
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(k);
      wr_data = 8'(v);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (!both_idle() && c < budget) begin
      tick();
      c++;
    end
    check("idle_reached", (c < budget) ? 1 : 0, 1);
  endtask

  // Start a frame, then either stall randomly or stall stall_len cycles at pixel stall_at.
  task automatic run_frame(input int w, input int h, input int stall_pct,
                           input int stall_at, input int stall_len);
    int c = 0;
    int left = 0;
    bit fired = 1'b0;
    int budget = w * h * 4 + h * 8 + 50;
    img_width  = 8'(w);
    img_height = 8'(h);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    img_width  = 8'($urandom);
    img_height = 8'($urandom);
    while (!both_idle() && c < budget) begin
      stall = 1'b0;
      if (stall_at >= 0) begin
        if (!fired && m_act[0] != 0 && m_prime[0] == 0 && m_k[0] == stall_at) begin
          fired = 1'b1;
          left  = stall_len;
        end
        if (left > 0) begin
          stall = 1'b1;
          left--;
        end
      end else begin
        stall = ($urandom_range(0, 99) < stall_pct);
      end
      tick();
      c++;
    end
    stall = 1'b0;
    check("frame_completed", (c < budget) ? 1 : 0, 1);
    tick();
  endtask

  task automatic reject(input int w, input int h);
    img_width  = 8'(w);
    img_height = 8'(h);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h, c;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 8x8 ramp, no stall
    load(8, 8, 0);
    run_frame(8, 8, 0, -1, 0);
    // same frame, 3-cycle stall at pixel 10
    run_frame(8, 8, 0, 10, 3);
    // conversion corners 0/128/255/127
    load(4, 4, 2);
    run_frame(4, 4, 0, -1, 0);
    // 4x4 random data with random stall (gap instance checks row gaps)
    load(4, 4, 1);
    run_frame(4, 4, 30, -1, 0);

    // rejected configurations, plus exact MAX_DIM accepted
    reject(0, 4);
    reject(4, MAX_DIM + 1);
    reject(MAX_DIM + 1, 4);
    reject(0, 0);
    load(MAX_DIM, 2, 1);
    run_frame(MAX_DIM, 2, 20, -1, 0);
    load(2, MAX_DIM, 1);
    run_frame(2, MAX_DIM, 20, -1, 0);
    load(1, 1, 1);
    run_frame(1, 1, 50, -1, 0);
    load(1, 5, 1);
    run_frame(1, 5, 25, -1, 0);
    load(7, 1, 1);
    run_frame(7, 1, 25, -1, 0);

    // random frames
    repeat (6) begin
      w = int'($urandom_range(1, 12));
      h = int'($urandom_range(1, 12));
      load(w, h, 1);
      run_frame(w, h, 25, -1, 0);
    end

    // reset at pixel 20, then restart from 0,0
    load(8, 8, 1);
    img_width  = 8'd8;
    img_height = 8'd8;
    start      = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!(m_act[0] != 0 && m_prime[0] == 0 && m_k[0] == 20) && c < 500) begin
      tick();
      c++;
    end
    check("reach_pixel20", (c < 500) ? 1 : 0, 1);
    check("pre_rst_valid", valid_w[0], 1);
    rst = 1'b1;
    #1;
    check("rst_valid_now", valid_w[0], 0);
    check("rst_busy_now", busy_w[0], 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_frame(8, 8, 0, -1, 0);

    // start held high with writes attempted while busy
    load(4, 4, 1);
    img_width  = 8'd4;
    img_height = 8'd4;
    start      = 1'b1;
    for (int n = 0; n < 90; n++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = ADDR_W'($urandom_range(0, 15));
      wr_data = 8'($urandom);
      stall   = ($urandom_range(0, 99) < 20);
      tick();
    end
    start = 1'b0;
    wr_en = 1'b0;
    stall = 1'b0;
    wait_idle(400);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
